// File: rtl/main_memory_arbiter.sv
// rtl/main_memory_arbiter.sv - round-robin arbiter and single-access sequencer for MainMemory
// Latches the winning request, drives one memory access, returns read data, then pulses done.
module main_memory_arbiter #(
  parameter int NREQ      = 2,
  parameter int INDEX_W   = 9,
  parameter int PAGE_W    = 16,
  parameter int MEM_DEPTH = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ*INDEX_W-1:0] req_index,
  input  logic [NREQ*PAGE_W-1:0]  req_page,
  input  logic [NREQ*32-1:0]      req_wdata,
  input  logic [NREQ*2-1:0]       req_mesi,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    err,
  output logic [31:0]             rdata,
  output logic [1:0]              rmesi,
  output logic [PAGE_W-1:0]       rpage,
  output logic [INDEX_W-1:0]      mem_index,
  output logic [PAGE_W-1:0]       mem_page,
  output logic [31:0]             mem_wdata,
  output logic [1:0]              mem_mesi,
  output logic                    mem_we,
  input  logic [31:0]             mem_rdata,
  input  logic [1:0]              mem_rmesi,
  input  logic [PAGE_W-1:0]       mem_rpage
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, COMPLETE} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_gnt_q, last_gnt_d;
  logic [ID_W-1:0]     winner_q, winner_d;
  logic                we_q, we_d;
  logic                oor_q, oor_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          mesi_q, mesi_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rmesi_q, rmesi_d;
  logic [PAGE_W-1:0]   rpage_q, rpage_d;

  logic                found;
  logic [ID_W-1:0]     pick;
  logic [INDEX_W-1:0]  pick_index;

  // Search starts one past the last grant and wraps, so a held request cannot starve others.
  always_comb begin
    int              cand;
    logic [ID_W-1:0] c;
    found = 1'b0;
    pick  = last_gnt_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_gnt_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      c = ID_W'(cand);
      if (!found && req[c]) begin
        found = 1'b1;
        pick  = c;
      end
    end
  end

  assign pick_index = req_index[int'(pick)*INDEX_W +: INDEX_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_gnt_q <= ID_W'(NREQ - 1);
      winner_q   <= '0;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      index_q    <= '0;
      page_q     <= '0;
      wdata_q    <= '0;
      mesi_q     <= '0;
      rdata_q    <= '0;
      rmesi_q    <= '0;
      rpage_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      winner_q   <= winner_d;
      we_q       <= we_d;
      oor_q      <= oor_d;
      index_q    <= index_d;
      page_q     <= page_d;
      wdata_q    <= wdata_d;
      mesi_q     <= mesi_d;
      rdata_q    <= rdata_d;
      rmesi_q    <= rmesi_d;
      rpage_q    <= rpage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (found) state_d = ISSUE;
      ISSUE:    state_d = CAPTURE;
      CAPTURE:  state_d = COMPLETE;
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Payload is frozen at grant; later requester changes are not seen.
  always_comb begin
    last_gnt_d = last_gnt_q;
    winner_d   = winner_q;
    we_d       = we_q;
    oor_d      = oor_q;
    index_d    = index_q;
    page_d     = page_q;
    wdata_d    = wdata_q;
    mesi_d     = mesi_q;
    rdata_d    = rdata_q;
    rmesi_d    = rmesi_q;
    rpage_d    = rpage_q;
    if (state_q == IDLE && found) begin
      winner_d   = pick;
      last_gnt_d = pick;
      we_d       = req_we[pick];
      index_d    = pick_index;
      oor_d      = (32'(pick_index) >= 32'(MEM_DEPTH));
      page_d     = req_page[int'(pick)*PAGE_W +: PAGE_W];
      wdata_d    = req_wdata[int'(pick)*32 +: 32];
      mesi_d     = req_mesi[int'(pick)*2 +: 2];
    end
    if (state_q == CAPTURE && !we_q && !oor_q) begin
      rdata_d = mem_rdata;
      rmesi_d = mem_rmesi;
      rpage_d = mem_rpage;
    end
  end

  always_comb begin
    gnt    = '0;
    done   = '0;
    err    = 1'b0;
    mem_we = 1'b0;
    case (state_q)
      ISSUE: begin
        gnt[winner_q] = 1'b1;
        mem_we        = we_q && !oor_q;
      end
      CAPTURE: gnt[winner_q] = 1'b1;
      COMPLETE: begin
        gnt[winner_q]  = 1'b1;
        done[winner_q] = 1'b1;
        err            = oor_q;
      end
      default: ;
    endcase
  end

  assign mem_index = index_q;
  assign mem_page  = page_q;
  assign mem_wdata = wdata_q;
  assign mem_mesi  = mesi_q;
  assign rdata     = rdata_q;
  assign rmesi     = rmesi_q;
  assign rpage     = rpage_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// tb/tb_main_memory_arbiter.sv - self-checking bench for main_memory_arbiter
// Behavioural MainMemory plus a scoreboard of expected completions.
module tb_main_memory_arbiter;
  localparam int NREQ = 2;
  localparam int IW   = 10;
  localparam int PW   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_we = '0;
  logic [NREQ*IW-1:0] req_index = '0;
  logic [NREQ*PW-1:0] req_page = '0;
  logic [NREQ*32-1:0] req_wdata = '0;
  logic [NREQ*2-1:0] req_mesi = '0;
  logic [NREQ-1:0]   gnt, done;
  logic              err, mem_we;
  logic [31:0]       rdata, mem_wdata;
  logic [1:0]        rmesi, mem_mesi;
  logic [PW-1:0]     rpage, mem_page;
  logic [IW-1:0]     mem_index;
  logic [31:0]       mem_rdata = '0;
  logic [1:0]        mem_rmesi = '0;
  logic [PW-1:0]     mem_rpage = '0;

  main_memory_arbiter #(.NREQ(NREQ), .INDEX_W(IW), .PAGE_W(PW), .MEM_DEPTH(512)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_index(req_index),
    .req_page(req_page), .req_wdata(req_wdata), .req_mesi(req_mesi), .gnt(gnt),
    .done(done), .err(err), .rdata(rdata), .rmesi(rmesi), .rpage(rpage),
    .mem_index(mem_index), .mem_page(mem_page), .mem_wdata(mem_wdata), .mem_mesi(mem_mesi),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_rmesi(mem_rmesi), .mem_rpage(mem_rpage)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_d [0:1023];
  logic [1:0]  mem_m [0:1023];
  logic [15:0] mem_p [0:1023];

  always @(posedge clk) begin
    if (mem_we) begin
      mem_d[mem_index] <= mem_wdata;
      mem_m[mem_index] <= mem_mesi;
      mem_p[mem_index] <= mem_page;
    end
    mem_rdata <= mem_d[mem_index];
    mem_rmesi <= mem_m[mem_index];
    mem_rpage <= mem_p[mem_index];
  end

  typedef struct {
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  rmesi;
    logic [15:0] rpage;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] sh_d [0:1023];
  logic [1:0]  sh_m [0:1023];
  logic [15:0] sh_p [0:1023];
  logic [31:0] lr_d;
  logic [1:0]  lr_m;
  logic [15:0] lr_p;
  int          checks = 0;
  int          failures = 0;

  task automatic preload();
    for (int i = 0; i < 1024; i++) begin
      sh_d[i] = 32'hA000_0000 | i;
      sh_m[i] = i[1:0];
      sh_p[i] = 16'h1000 | i[15:0];
    end
    sh_d[5] = 32'hDEADBEEF;
    sh_m[5] = 2'b11;
    sh_p[5] = 16'h0001;
    for (int i = 0; i < 1024; i++) begin
      mem_d[i] = sh_d[i];
      mem_m[i] = sh_m[i];
      mem_p[i] = sh_p[i];
    end
  endtask

  task automatic set_payload(input int id, input logic we, input logic [IW-1:0] idx,
                             input logic [31:0] wd, input logic [1:0] ms, input logic [15:0] pg);
    req_we[id]              = we;
    req_index[id*IW +: IW]  = idx;
    req_wdata[id*32 +: 32]  = wd;
    req_mesi[id*2 +: 2]     = ms;
    req_page[id*PW +: PW]   = pg;
  endtask

  task automatic sb_push(input int id, input logic we, input logic [IW-1:0] idx,
                         input logic [31:0] wd, input logic [1:0] ms, input logic [15:0] pg);
    exp_t x;
    x.done = 2'b01 << id;
    x.err  = (idx >= 512);
    if (!x.err && we) begin
      sh_d[idx] = wd;
      sh_m[idx] = ms;
      sh_p[idx] = pg;
    end
    if (!x.err && !we) begin
      lr_d = sh_d[idx];
      lr_m = sh_m[idx];
      lr_p = sh_p[idx];
    end
    x.rdata = lr_d;
    x.rmesi = lr_m;
    x.rpage = lr_p;
    sb.push_back(x);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    lr_d = '0;
    lr_m = '0;
    lr_p = '0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done != '0) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({gnt, done, err, mem_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl gnt=%b done=%b err=%b mem_we=%b required 0", gnt, done, err, mem_we);
    end
    checks++;
    if ({rdata, rmesi, rpage} !== 50'b0) begin
      failures++;
      $display("FAIL reset_rdata rdata=%h rmesi=%b rpage=%h required 0", rdata, rmesi, rpage);
    end
    checks++;
    if ({mem_index, mem_page, mem_wdata, mem_mesi} !== 60'b0) begin
      failures++;
      $display("FAIL reset_mem idx=%h page=%h wdata=%h mesi=%b required 0", mem_index, mem_page, mem_wdata, mem_mesi);
    end
  endtask

  task automatic test_read_latency();
    set_payload(0, 1'b0, 10'd5, 32'h0, 2'b00, 16'h0);
    sb_push(0, 1'b0, 10'd5, 32'h0, 2'b00, 16'h0);
    req = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (gnt !== 2'b01 || done !== ((c == 3) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL read_cycle%0d gnt=%b done=%b required gnt=01 done=%b", c, gnt, done, (c == 3) ? 2'b01 : 2'b00);
      end
    end
    e = sb.pop_front();
    checks++;
    if ({done, err, rdata, rmesi, rpage} !== {e.done, e.err, e.rdata, e.rmesi, e.rpage}) begin
      failures++;
      $display("FAIL read_sb done=%b err=%b rdata=%h rmesi=%b rpage=%h required %b %b %h %b %h",
               done, err, rdata, rmesi, rpage, e.done, e.err, e.rdata, e.rmesi, e.rpage);
    end
    checks++;
    if ({rdata, rmesi, rpage} !== {32'hDEADBEEF, 2'b11, 16'h0001}) begin
      failures++;
      $display("FAIL read_const rdata=%h rmesi=%b rpage=%h required DEADBEEF 11 0001", rdata, rmesi, rpage);
    end
    req = '0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00) begin
      failures++;
      $display("FAIL read_idle_gnt gnt=%b required 00", gnt);
    end
  endtask

  task automatic test_write_readback();
    int wecnt;
    int cyc;
    wecnt = 0;
    cyc = -1;
    set_payload(1, 1'b1, 10'd10, 32'h12345678, 2'b01, 16'h0002);
    sb_push(1, 1'b1, 10'd10, 32'h12345678, 2'b01, 16'h0002);
    req = 2'b10;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_we) wecnt++;
      if (done != '0) begin
        cyc = i;
        break;
      end
    end
    checks++;
    if (cyc !== 3 || wecnt !== 1) begin
      failures++;
      $display("FAIL write_we latency=%0d mem_we_cycles=%0d required 3 and 1", cyc, wecnt);
    end
    e = sb.pop_front();
    checks++;
    if ({done, err, rdata, rmesi, rpage} !== {e.done, e.err, e.rdata, e.rmesi, e.rpage}) begin
      failures++;
      $display("FAIL write_sb done=%b err=%b rdata=%h required %b %b %h", done, err, rdata, e.done, e.err, e.rdata);
    end
    req = '0;
    @(posedge clk);
    @(negedge clk);
    set_payload(0, 1'b0, 10'd10, 32'h0, 2'b00, 16'h0);
    sb_push(0, 1'b0, 10'd10, 32'h0, 2'b00, 16'h0);
    req = 2'b01;
    wait_done(cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 3 || {done, err, rdata, rmesi, rpage} !== {e.done, e.err, e.rdata, e.rmesi, e.rpage}) begin
      failures++;
      $display("FAIL readback_sb latency=%0d done=%b rdata=%h rmesi=%b rpage=%h required 3 %b %h %b %h",
               cyc, done, rdata, rmesi, rpage, e.done, e.rdata, e.rmesi, e.rpage);
    end
    checks++;
    if ({rdata, rmesi, rpage} !== {32'h12345678, 2'b01, 16'h0002}) begin
      failures++;
      $display("FAIL readback_const rdata=%h rmesi=%b rpage=%h required 12345678 01 0002", rdata, rmesi, rpage);
    end
    req = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ndone;
    int last_c;
    int bad_gap;
    ndone = 0;
    last_c = 0;
    bad_gap = 0;
    reset_dut();
    set_payload(0, 1'b0, 10'd20, 32'h0, 2'b00, 16'h0);
    set_payload(1, 1'b0, 10'd21, 32'h0, 2'b00, 16'h0);
    sb_push(0, 1'b0, 10'd20, 32'h0, 2'b00, 16'h0);
    sb_push(1, 1'b0, 10'd21, 32'h0, 2'b00, 16'h0);
    sb_push(0, 1'b0, 10'd20, 32'h0, 2'b00, 16'h0);
    sb_push(1, 1'b0, 10'd21, 32'h0, 2'b00, 16'h0);
    req = 2'b11;
    for (int c = 1; c <= 40 && ndone < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done != '0) begin
        if (c - last_c != ((ndone == 0) ? 3 : 4)) bad_gap++;
        last_c = c;
        ndone++;
        e = sb.pop_front();
        checks++;
        if ({done, err, rdata, rmesi, rpage} !== {e.done, e.err, e.rdata, e.rmesi, e.rpage}) begin
          failures++;
          $display("FAIL b2b_sb%0d done=%b rdata=%h rmesi=%b rpage=%h required %b %h %b %h",
                   ndone, done, rdata, rmesi, rpage, e.done, e.rdata, e.rmesi, e.rpage);
        end
        if (ndone == 4) req = '0;
      end
    end
    checks++;
    if (ndone !== 4 || bad_gap !== 0) begin
      failures++;
      $display("FAIL b2b_timing dones=%0d bad_gaps=%0d required 4 and 0", ndone, bad_gap);
    end
    req = '0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    int wecnt;
    int errcnt;
    int cyc;
    wecnt = 0;
    errcnt = 0;
    cyc = -1;
    set_payload(0, 1'b1, 10'd600, 32'hCAFEF00D, 2'b10, 16'h0BAD);
    sb_push(0, 1'b1, 10'd600, 32'hCAFEF00D, 2'b10, 16'h0BAD);
    req = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_we) wecnt++;
      if (err) errcnt++;
      if (done != '0) begin
        cyc = i;
        break;
      end
    end
    e = sb.pop_front();
    checks++;
    if (cyc !== 3 || {done, err, rdata, rmesi, rpage} !== {e.done, e.err, e.rdata, e.rmesi, e.rpage}) begin
      failures++;
      $display("FAIL oor_sb latency=%0d done=%b err=%b rdata=%h required 3 %b %b %h", cyc, done, err, rdata, e.done, e.err, e.rdata);
    end
    checks++;
    if (wecnt !== 0 || errcnt !== 1) begin
      failures++;
      $display("FAIL oor_we mem_we_cycles=%0d err_cycles=%0d required 0 and 1", wecnt, errcnt);
    end
    req = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int cyc;
    set_payload(0, 1'b1, 10'd30, 32'h55AA55AA, 2'b10, 16'h0030);
    req = 2'b01;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({gnt, done, err, mem_we, rdata, rmesi, rpage} !== 56'b0) begin
      failures++;
      $display("FAIL async_rst_out gnt=%b done=%b err=%b mem_we=%b rdata=%h required 0", gnt, done, err, mem_we, rdata);
    end
    checks++;
    if ({mem_index, mem_page, mem_wdata, mem_mesi} !== 60'b0) begin
      failures++;
      $display("FAIL async_rst_mem idx=%h wdata=%h required 0", mem_index, mem_wdata);
    end
    sh_d[30] = 32'h55AA55AA;
    sh_m[30] = 2'b10;
    sh_p[30] = 16'h0030;
    reset_dut();
    set_payload(0, 1'b0, 10'd5, 32'h0, 2'b00, 16'h0);
    set_payload(1, 1'b0, 10'd20, 32'h0, 2'b00, 16'h0);
    sb_push(0, 1'b0, 10'd5, 32'h0, 2'b00, 16'h0);
    sb_push(1, 1'b0, 10'd20, 32'h0, 2'b00, 16'h0);
    req = 2'b11;
    for (int k = 0; k < 2; k++) begin
      wait_done(cyc);
      e = sb.pop_front();
      checks++;
      if (cyc !== ((k == 0) ? 3 : 4) || {done, rdata, rmesi, rpage} !== {e.done, e.rdata, e.rmesi, e.rpage}) begin
        failures++;
        $display("FAIL post_rst_order%0d latency=%0d done=%b rdata=%h required %b %h", k, cyc, done, rdata, e.done, e.rdata);
      end
      if (k == 1) req = '0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_withdrawn();
    int cyc;
    int bad;
    cyc = -1;
    bad = 0;
    set_payload(1, 1'b0, 10'd5, 32'h0, 2'b00, 16'h0);
    set_payload(0, 1'b0, 10'd21, 32'h0, 2'b00, 16'h0);
    sb_push(1, 1'b0, 10'd5, 32'h0, 2'b00, 16'h0);
    req = 2'b10;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    for (int i = 3; i <= 20; i++) begin
      if (done != '0) begin
        cyc = i - 1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if (cyc !== 3 || {done, rdata, rmesi, rpage} !== {e.done, e.rdata, e.rmesi, e.rpage}) begin
      failures++;
      $display("FAIL withdrawn_sb latency=%0d done=%b rdata=%h required 3 %b %h", cyc, done, rdata, e.done, e.rdata);
    end
    req = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (gnt != '0 || done != '0 || mem_we) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL withdrawn_idle active_cycles=%0d required 0", bad);
    end
  endtask

  initial begin
    preload();
    test_reset();
    test_read_latency();
    test_write_readback();
    test_back_to_back();
    test_out_of_range();
    test_async_reset();
    test_withdrawn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
